// File: rtl/reflet_float_mult_seq.sv
// Sequential IEEE-754-style multiplier: shift-add mantissa product, RNE or truncate, flush-to-zero.
// Latency: accept -> out_valid K+2 cycles later (K = ceil((M+1)/bits_per_cycle)); specials 1 cycle.
// Backpressure: in_ready only in IDLE; the result is held in DONE until out_ready is seen.
//
// Ports:
//   clk, reset (async, active-low)
//   in_valid/in_ready   operand handshake, in1/in2 operands
//   out_valid/out_ready result handshake, mult product, flags {invalid, overflow, underflow, inexact}
module reflet_float_mult_seq #(
    parameter int float_size     = 32,
    parameter int bits_per_cycle = 1,
    parameter bit round_enable   = 1'b1
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [float_size-1:0] in1,
    input  logic [float_size-1:0] in2,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [float_size-1:0] mult,
    output logic [3:0]            flags
);

    function automatic int exponent_size(input int fs);
        case (fs)
            16:      return 5;
            64:      return 11;
            default: return 8;
        endcase
    endfunction

    localparam int E  = exponent_size(float_size);
    localparam int M  = float_size - E - 1;
    localparam int P  = 2 * M + 2;                               // full product width
    localparam int K  = (M + bits_per_cycle) / bits_per_cycle;   // ceil((M+1)/B)
    localparam int BW = K * bits_per_cycle;                      // multiplier reg, zero-padded for a partial last step
    localparam int CW = $clog2(K + 1);
    localparam int EW = E + 2;                                   // signed exponent with headroom

    localparam logic signed [EW-1:0] BIAS    = EW'((1 << (E - 1)) - 1);
    localparam logic signed [EW-1:0] EXP_MAX = EW'((1 << E) - 1);
    localparam logic [float_size-1:0] QNAN   = {1'b0, {E{1'b1}}, 1'b1, {(M - 1){1'b0}}};

    typedef enum logic [1:0] {IDLE, MULT, NORM, DONE} state_t;

    state_t                 state;
    logic [P-1:0]           a_sh;       // multiplicand, shifted left B bits per step
    logic [BW-1:0]          b_sh;       // multiplier, shifted right B bits per step
    logic [P-1:0]           acc;
    logic [CW-1:0]          cnt;
    logic                   sign_r;
    logic signed [EW-1:0]   exp_sum;    // exp1 + exp2 - bias, before normalisation

    // ---------------- operand decode and special cases ----------------
    logic          sgn1, sgn2;
    logic [E-1:0]  exp1, exp2;
    logic [M-1:0]  mnt1, mnt2;
    logic          zero1, zero2, inf1, inf2, nan1, nan2;

    assign {sgn1, exp1, mnt1} = in1;
    assign {sgn2, exp2, mnt2} = in2;

    // exp==0 covers subnormals too: they are flushed and treated as zero
    assign zero1 = (exp1 == '0);
    assign zero2 = (exp2 == '0);
    assign inf1  = (&exp1) && (mnt1 == '0);
    assign inf2  = (&exp2) && (mnt2 == '0);
    assign nan1  = (&exp1) && (|mnt1);
    assign nan2  = (&exp2) && (|mnt2);

    logic                  special;
    logic [float_size-1:0] spec_res;
    logic [3:0]            spec_flags;

    always_comb begin
        special    = 1'b0;
        spec_res   = '0;
        spec_flags = 4'b0000;
        if (nan1 || nan2) begin
            special  = 1'b1;
            spec_res = QNAN;
        end else if ((inf1 && zero2) || (zero1 && inf2)) begin
            special    = 1'b1;
            spec_res   = QNAN;
            spec_flags = 4'b1000;
        end else if (inf1 || inf2) begin
            special  = 1'b1;
            spec_res = {sgn1 ^ sgn2, {E{1'b1}}, {M{1'b0}}};
        end else if (zero1 || zero2) begin
            special  = 1'b1;
            spec_res = {sgn1 ^ sgn2, {(float_size - 1){1'b0}}};
        end
    end

    // ---------------- shift-add step ----------------
    logic [P-1:0] acc_nxt;

    always_comb begin
        acc_nxt = acc;
        for (int j = 0; j < bits_per_cycle; j++) begin
            if (b_sh[j]) acc_nxt = acc_nxt + (a_sh << j);
        end
    end

    // ---------------- normalise / round / range check ----------------
    logic                  hi;
    logic [M-1:0]          mnt_raw;
    logic [M-1:0]          mnt_rnd;
    logic                  guard, sticky, rnd_up, carry, inexact;
    logic signed [EW-1:0]  e_pre, e_fin;
    logic [float_size-1:0] norm_res;
    logic [3:0]            norm_flags;

    always_comb begin
        hi = acc[P-1];
        if (hi) begin
            mnt_raw = acc[P-2:M+1];
            guard   = acc[M];
            sticky  = |acc[M-1:0];
        end else begin
            mnt_raw = acc[P-3:M];
            guard   = acc[M-1];
            sticky  = |acc[M-2:0];
        end
        e_pre            = exp_sum + $signed({{(EW - 1){1'b0}}, hi});
        rnd_up           = round_enable && guard && (sticky || mnt_raw[0]);
        {carry, mnt_rnd} = {1'b0, mnt_raw} + {{M{1'b0}}, rnd_up};
        // a rounding carry-out leaves mnt_rnd at zero and bumps the exponent
        e_fin            = e_pre + $signed({{(EW - 1){1'b0}}, carry});
        inexact          = guard || sticky;

        if (e_fin >= EXP_MAX) begin
            norm_res   = {sign_r, {E{1'b1}}, {M{1'b0}}};
            norm_flags = 4'b0101;
        end else if (e_fin <= 0) begin
            norm_res   = {sign_r, {(float_size - 1){1'b0}}};
            norm_flags = 4'b0011;
        end else begin
            norm_res   = {sign_r, e_fin[E-1:0], mnt_rnd};
            norm_flags = {3'b000, inexact};
        end
    end

    // ---------------- control FSM ----------------
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state     <= IDLE;
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
            mult      <= '0;
            flags     <= 4'b0000;
            a_sh      <= '0;
            b_sh      <= '0;
            acc       <= '0;
            cnt       <= '0;
            sign_r    <= 1'b0;
            exp_sum   <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid && in_ready) begin
                        in_ready <= 1'b0;
                        sign_r   <= sgn1 ^ sgn2;
                        if (special) begin
                            mult      <= spec_res;
                            flags     <= spec_flags;
                            out_valid <= 1'b1;
                            state     <= DONE;
                        end else begin
                            a_sh    <= P'({1'b1, mnt1});
                            b_sh    <= BW'({1'b1, mnt2});
                            acc     <= '0;
                            cnt     <= '0;
                            exp_sum <= $signed(EW'(exp1)) + $signed(EW'(exp2)) - BIAS;
                            state   <= MULT;
                        end
                    end
                end
                MULT: begin
                    acc  <= acc_nxt;
                    a_sh <= a_sh << bits_per_cycle;
                    b_sh <= b_sh >> bits_per_cycle;
                    cnt  <= cnt + 1'b1;
                    if (cnt == CW'(K - 1)) state <= NORM;
                end
                NORM: begin
                    mult      <= norm_res;
                    flags     <= norm_flags;
                    out_valid <= 1'b1;
                    state     <= DONE;
                end
                DONE: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        in_ready  <= 1'b1;
                        state     <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_reflet_float_mult_seq.sv
// Bench for reflet_float_mult_seq (fp32, B=1): two instances, round-to-nearest-even and truncating.
// Latency: cycle numbering counts the accept cycle as 0; each rising edge after it starts the next.
// Backpressure: out_ready normally high; one case stalls the result for several cycles.
module tb_reflet_float_mult_seq;

    logic        clk;
    logic        reset;
    logic        in_valid;
    logic [31:0] in1, in2;
    logic        out_ready;

    logic        rdy_rne, rdy_trn;
    logic        vld_rne, vld_trn;
    logic [31:0] mult_rne, mult_trn;
    logic [3:0]  flags_rne, flags_trn;

    reflet_float_mult_seq #(.float_size(32), .bits_per_cycle(1), .round_enable(1'b1)) u_rne (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(rdy_rne),
        .in1(in1), .in2(in2), .out_valid(vld_rne), .out_ready(out_ready),
        .mult(mult_rne), .flags(flags_rne)
    );

    reflet_float_mult_seq #(.float_size(32), .bits_per_cycle(1), .round_enable(1'b0)) u_trn (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(rdy_trn),
        .in1(in1), .in2(in2), .out_valid(vld_trn), .out_ready(out_ready),
        .mult(mult_trn), .flags(flags_trn)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] r_rne;
        logic [31:0] r_trn;
        logic [3:0]  f;
        int          lat;
    } vec_t;

    typedef struct {
        logic [31:0] r_rne;
        logic [31:0] r_trn;
        logic [3:0]  f;
        int          lat;
        int          acc_cyc;
    } exp_t;

    vec_t vecs[$];
    exp_t sb[$];
    int   n_checks = 0;
    int   n_fail   = 0;
    int   cyc      = 0;
    bit   lat_seen = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] expv);
        n_checks++;
        if (act !== expv) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, expv, $time);
        end
    endtask

    task automatic add(input logic [31:0] a, input logic [31:0] b, input logic [31:0] r,
                       input logic [31:0] t, input logic [3:0] f, input int lat);
        vecs.push_back('{a, b, r, t, f, lat});
    endtask

    // Monitor: first-valid latency check, then full result check on each handshake.
    always @(negedge clk) begin
        if (!reset) begin
            lat_seen = 1'b0;
        end else begin
            if (vld_rne && !lat_seen) begin
                lat_seen = 1'b1;
                if (sb.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL unexpected_output: got mult %0h with no pending operation", mult_rne);
                end else begin
                    check("latency", 64'(cyc - sb[0].acc_cyc + 1), 64'(sb[0].lat));
                end
            end
            if (vld_rne && out_ready && sb.size() != 0) begin
                exp_t e;
                e = sb.pop_front();
                check("mult_rne",  64'(mult_rne),  64'(e.r_rne));
                check("flags_rne", 64'(flags_rne), 64'(e.f));
                check("valid_trn", 64'(vld_trn),   64'd1);
                check("mult_trn",  64'(mult_trn),  64'(e.r_trn));
                check("flags_trn", 64'(flags_trn), 64'(e.f));
                lat_seen = 1'b0;
            end
        end
    end

    task automatic issue(input vec_t v);
        int   t;
        exp_t e;
        t = 0;
        @(negedge clk);
        while (!(rdy_rne && rdy_trn) && t < 200) begin
            @(negedge clk);
            t++;
        end
        if (t >= 200) begin
            n_checks++;
            n_fail++;
            $display("FAIL issue_timeout: in_ready got 0 expected 1 within 200 cycles");
        end
        in1      = v.a;
        in2      = v.b;
        in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        e.r_rne   = v.r_rne;
        e.r_trn   = v.r_trn;
        e.f       = v.f;
        e.lat     = v.lat;
        e.acc_cyc = cyc;
        sb.push_back(e);
    endtask

    task automatic drain();
        int t;
        t = 0;
        while (sb.size() != 0 && t < 200) begin
            @(negedge clk);
            t++;
        end
        if (t >= 200) begin
            n_checks++;
            n_fail++;
            $display("FAIL drain_timeout: pending results got %0d expected 0", sb.size());
        end
    endtask

    initial begin
        int t;
        reset     = 1'b1;
        in_valid  = 1'b0;
        in1       = '0;
        in2       = '0;
        out_ready = 1'b1;

        //  a          b          rne        trunc      flags    lat
        add(32'h40400000, 32'h40000000, 32'h40C00000, 32'h40C00000, 4'b0000, 26); // 3 x 2
        add(32'h3F800001, 32'h3F800001, 32'h3F800002, 32'h3F800002, 4'b0001, 26); // sticky only
        add(32'h7F000000, 32'h40000000, 32'h7F800000, 32'h7F800000, 4'b0101, 26); // overflow, e==255
        add(32'hFF000000, 32'h40000000, 32'hFF800000, 32'hFF800000, 4'b0101, 26); // negative overflow
        add(32'h7F000000, 32'h3FFFFFFF, 32'h7F7FFFFF, 32'h7F7FFFFF, 4'b0000, 26); // largest finite
        add(32'h00800000, 32'h3F000000, 32'h00000000, 32'h00000000, 4'b0011, 26); // underflow, e==0
        add(32'h80800000, 32'h3F000000, 32'h80000000, 32'h80000000, 4'b0011, 26); // signed underflow
        add(32'h7F800000, 32'h80000000, 32'h7FC00000, 32'h7FC00000, 4'b1000, 1);  // inf x -0
        add(32'h80000000, 32'h7F800000, 32'h7FC00000, 32'h7FC00000, 4'b1000, 1);  // -0 x inf
        add(32'hFF800000, 32'h40000000, 32'hFF800000, 32'hFF800000, 4'b0000, 1);  // -inf x 2
        add(32'h7F800001, 32'h3F800000, 32'h7FC00000, 32'h7FC00000, 4'b0000, 1);  // NaN in
        add(32'h00000000, 32'hC0000000, 32'h80000000, 32'h80000000, 4'b0000, 1);  // 0 x -2
        add(32'h00000001, 32'h40000000, 32'h00000000, 32'h00000000, 4'b0000, 1);  // subnormal flushed
        add(32'h3FC00001, 32'h3FC00001, 32'h40100002, 32'h40100001, 4'b0001, 26); // rounds up
        add(32'h3F800001, 32'h3FC00000, 32'h3FC00002, 32'h3FC00001, 4'b0001, 26); // tie, odd lsb
        add(32'h3F800003, 32'h3FC00000, 32'h3FC00004, 32'h3FC00004, 4'b0001, 26); // tie, even lsb
        add(32'hC0400000, 32'h40000000, 32'hC0C00000, 32'hC0C00000, 4'b0000, 26); // -3 x 2
        add(32'h3F800000, 32'h3F800000, 32'h3F800000, 32'h3F800000, 4'b0000, 26); // 1 x 1

        #1 reset = 1'b0;
        #1;
        check("reset_out_valid", 64'(vld_rne),   64'd0);
        check("reset_mult",      64'(mult_rne),  64'd0);
        check("reset_flags",     64'(flags_rne), 64'd0);
        check("reset_in_ready",  64'(rdy_rne),   64'd1);
        check("reset_in_ready_trn", 64'(rdy_trn), 64'd1);
        repeat (2) @(negedge clk);
        reset = 1'b1;

        foreach (vecs[i]) issue(vecs[i]);
        drain();

        // Stall the result: it must stay put while out_ready is low.
        out_ready = 1'b0;
        issue(vecs[0]);
        t = 0;
        while (!vld_rne && t < 100) begin
            @(negedge clk);
            t++;
        end
        check("stall_reached_done", 64'(vld_rne), 64'd1);
        repeat (5) begin
            @(negedge clk);
            check("stall_out_valid", 64'(vld_rne),   64'd1);
            check("stall_mult",      64'(mult_rne),  64'h40C00000);
            check("stall_flags",     64'(flags_rne), 64'd0);
            check("stall_in_ready",  64'(rdy_rne),   64'd0);
        end
        @(posedge clk);
        #1 out_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        check("release_out_valid", 64'(vld_rne), 64'd0);
        check("release_in_ready",  64'(rdy_rne), 64'd1);
        drain();

        // Abort mid-multiply: previous result (0x40C00000) must be wiped and nothing emitted.
        issue(vecs[0]);
        repeat (9) @(posedge clk);
        #2 reset = 1'b0;
        #1;
        check("abort_out_valid", 64'(vld_rne),   64'd0);
        check("abort_mult",      64'(mult_rne),  64'd0);
        check("abort_flags",     64'(flags_rne), 64'd0);
        check("abort_in_ready",  64'(rdy_rne),   64'd1);
        check("abort_mult_trn",  64'(mult_trn),  64'd0);
        sb.delete();
        repeat (2) @(negedge clk);
        reset = 1'b1;
        repeat (3) @(negedge clk);
        check("post_abort_idle", 64'(vld_rne), 64'd0);

        begin
            vec_t v;
            v = '{32'h3FC00000, 32'h3FC00000, 32'h40100000, 32'h40100000, 4'b0000, 26};
            issue(v);
        end
        drain();

        repeat (3) @(negedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
